// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable glitch-free clock divider with tick enable
// Divisor and stop requests are applied only at period boundaries so clk_out never produces a short pulse.
module clock_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             at_wrap;
  logic             hs;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] idle_div;
  logic [WIDTH:0]   half_d;

  assign at_wrap  = (state_q == RUN) &&
                    (({1'b0, cnt_q} + (WIDTH+1)'(1)) == {1'b0, div_act_q});
  // A pending divisor is consumed on the wrap edge, so one more can be accepted then.
  assign div_ready = !pend_v_q || at_wrap;
  assign hs        = div_valid && div_ready;
  assign next_div  = pend_v_q ? pend_q : div_act_q;
  assign idle_div  = hs ? div_in : div_act_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_act_q <= DEF_DIV;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hs) div_act_d = div_in;
        if (en && (idle_div >= MIN_DIV)) state_d = RUN;
      end
      RUN: begin
        if (at_wrap) begin
          cnt_d = '0;
          if (pend_v_q) begin
            div_act_d = pend_q;
            pend_v_d  = 1'b0;
          end
          if (!en || (next_div < MIN_DIV)) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        // A load on the wrap edge overrides the clear above and becomes the next pending value.
        if (hs) begin
          pend_d   = div_in;
          pend_v_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    half_d    = ({1'b0, div_act_d} + (WIDTH+1)'(1)) >> 1;
    clk_out_d = (state_d == RUN) && ({1'b0, cnt_d} < half_d);
    tick_d    = (state_d == RUN) && ((state_q == IDLE) || at_wrap);
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         clk_out;
  logic         tick;
  logic         running;

  clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(10)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
  );

  always #10 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  bit m_run;
  int m_cnt;
  int m_div;
  int m_pend;
  bit m_pv;

  typedef struct {
    int div;
    int exp_high;
    int exp_low;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_div = 10; m_pend = 0; m_pv = 1'b0;
  endtask

  function automatic bit m_ready();
    return !m_pv || (m_run && (m_cnt == m_div - 1));
  endfunction

  // Advance the reference by one clk_in edge using the inputs currently driven.
  task automatic model_edge();
    bit hs;
    bit e_clk;
    bit e_tick;
    hs = div_valid && m_ready();
    if (!m_run) begin
      if (hs) m_div = int'(div_in);
      if (en && m_div >= 2) begin
        m_run = 1'b1;
        m_cnt = 0;
      end
    end else if (m_cnt == m_div - 1) begin
      if (m_pv) begin
        m_div = m_pend;
        m_pv  = 1'b0;
      end
      if (hs) begin
        m_pend = int'(div_in);
        m_pv   = 1'b1;
      end
      m_cnt = 0;
      if (!en || m_div < 2) m_run = 1'b0;
    end else begin
      m_cnt++;
      if (hs) begin
        m_pend = int'(div_in);
        m_pv   = 1'b1;
      end
    end
    e_clk  = m_run && (m_cnt < (m_div + 1) / 2);
    e_tick = m_run && (m_cnt == 0);
    exp_q.push_back({e_clk, e_tick, m_run, m_ready()});
  endtask

  task automatic step();
    logic [3:0] e;
    model_edge();
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check("cycle {clk_out,tick,running,div_ready}",
          int'({clk_out, tick, running, div_ready}), int'(e));
  endtask

  // Measure the period that starts at the next (or current) tick sample.
  task automatic measure(input int eh, input int el, input string tag);
    int k;
    int hi;
    int lo;
    bit seen;
    k = 0;
    while (!tick && k < 100) begin
      step();
      k++;
    end
    check({tag, " tick seen"}, int'(tick), 1);
    hi = 1; lo = 0; seen = 1'b0; k = 0;
    while (!seen && k < 200) begin
      step();
      k++;
      if (tick) seen = 1'b1;
      else if (clk_out) hi++;
      else lo++;
    end
    check({tag, " next tick"}, int'(seen), 1);
    check({tag, " high cycles"}, hi, eh);
    check({tag, " low cycles"}, lo, el);
  endtask

  task automatic stop_wait(input int limit, input string tag);
    int n;
    n = 0;
    while (running && n < limit) begin
      step();
      n++;
    end
    check({tag, " stopped"}, int'(running), 0);
  endtask

  task automatic run_vec(input int div, input int eh, input int el);
    en = 1'b0;
    stop_wait(64, "vec");
    div_in = W'(div);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    en = 1'b1;
    measure(eh, el, $sformatf("vec N=%0d", div));
  endtask

  initial begin
    int n;
    tbl[0] = '{2, 1, 1};
    tbl[1] = '{3, 2, 1};
    tbl[2] = '{5, 3, 2};
    tbl[3] = '{7, 4, 3};
    tbl[4] = '{4, 2, 2};
    tbl[5] = '{10, 5, 5};

    rst = 1'b1; en = 1'b0; div_valid = 1'b0; div_in = '0;
    model_reset();
    @(posedge clk_in);
    #1;
    check("reset clk_out", int'(clk_out), 0);
    check("reset tick", int'(tick), 0);
    check("reset running", int'(running), 0);
    check("reset div_ready", int'(div_ready), 1);
    rst = 1'b0;

    // default divisor: first tick one cycle after en, 5 high / 5 low, 10 cycles per tick
    en = 1'b1;
    step();
    check("first tick after en", int'(tick), 1);
    measure(5, 5, "default N=10");
    n = 0;
    step();
    n++;
    while (!tick && n < 50) begin
      step();
      n++;
    end
    check("tick spacing N=10", n, 10);

    // load 5 while running
    step(); step();
    div_in = W'(5);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("div_ready low while pending", int'(div_ready), 0);
    measure(3, 2, "reload N=5");

    for (int i = 0; i < 6; i++) run_vec(tbl[i].div, tbl[i].exp_high, tbl[i].exp_low);

    // en dropped at cnt=3: period completes, then IDLE
    step(); step(); step();
    en = 1'b0;
    n = 0;
    while (running && n < 40) begin
      step();
      n++;
    end
    check("stop latency from cnt=3", n, 7);
    check("clk_out low after stop", int'(clk_out), 0);

    // divisor 1 while running: finish period, park in IDLE until N>=2 arrives
    en = 1'b1;
    step();
    check("restart tick", int'(tick), 1);
    step(); step();
    div_in = W'(1);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    n = 0;
    while (running && n < 40) begin
      step();
      n++;
    end
    check("stop latency after N=1", n, 7);
    for (int i = 0; i < 5; i++) step();
    check("parked running", int'(running), 0);
    check("parked clk_out", int'(clk_out), 0);
    div_in = W'(4);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("restart with N=4", int'(tick), 1);
    measure(2, 2, "N=4 restart");

    // pend=6 loaded, then 8 handshaken on the wrap cycle
    div_in = W'(6);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("div_ready low with pend=6", int'(div_ready), 0);
    n = 0;
    while (!(m_run && m_cnt == m_div - 1) && n < 20) begin
      step();
      n++;
    end
    check("div_ready on wrap cycle", int'(div_ready), 1);
    div_in = W'(8);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("div_ready low with pend=8", int'(div_ready), 0);
    measure(3, 3, "period N=6");
    measure(4, 4, "period N=8");
    check("div_ready after pend drained", int'(div_ready), 1);

    // async reset mid-period discards pend and restores the default divisor
    div_in = W'(3);
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #4;
    rst = 1'b1;
    #1;
    check("async rst clk_out", int'(clk_out), 0);
    check("async rst tick", int'(tick), 0);
    check("async rst running", int'(running), 0);
    check("async rst div_ready", int'(div_ready), 1);
    model_reset();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    en = 1'b1;
    measure(5, 5, "post-reset period 1");
    measure(5, 5, "post-reset period 2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
